// File: rtl/clock_set_if.sv
// Bundle between the button/prescaler front end and the time-setting controller.
// The master side (front end) drives tick and button levels. The slave side
// (controller) drives the counter-chain controls and the display blank enables.
interface clock_set_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_cin;
    logic       min_force;
    logic       hour_force;
    logic       sec_clr_n;
    logic [1:0] mode;
    logic       blank_hour;
    logic       blank_min;

    modport master (
        output tick, btn_mode, btn_inc,
        input  sec_cin, min_force, hour_force, sec_clr_n, mode, blank_hour, blank_min
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output sec_cin, min_force, hour_force, sec_clr_n, mode, blank_hour, blank_min
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode and time-setting controller for the sec/min/hour counter chain.
// In RUN it forwards the 1 Hz tick into the seconds stage. In SET_HOUR and
// SET_MIN it freezes time and injects forced increments, with edge-triggered
// and auto-repeat presses. It blinks the digits being set and falls back to
// RUN after an idle timeout.
// All outputs are registered. Decisions are made combinationally from the
// current inputs and state, so every effect appears one clk after its cause.
module clock_set_ctrl #(
    parameter int IDLE_TIMEOUT = 10,
    parameter int REPEAT_DLY   = 2
) (
    input  logic         clk,
    input  logic         rst,
    clock_set_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    // Counters are 8 bits wide; both thresholds are limited to 1..255.
    localparam logic [7:0] REPEAT_W = 8'(REPEAT_DLY);
    localparam logic [7:0] IDLE_M1  = 8'(IDLE_TIMEOUT - 1);

    state_t     state;
    logic       prev_mode;
    logic       prev_inc;
    logic       blink_phase;
    logic [7:0] hold_cnt;
    logic [7:0] idle_cnt;

    logic       mode_ev;
    logic       inc_ev;
    logic       in_set;
    logic       rep_ev;
    logic       timeout;
    logic       inc_fire;
    logic       clr_pulse;
    logic       state_chg;
    state_t     next_state;
    logic       next_blink;
    logic [7:0] next_hold;
    logic [7:0] next_idle;

    // Decode button edges, auto-repeat, timeout, and all next-state values.
    always_comb begin
        mode_ev    = bus.btn_mode & ~prev_mode;
        inc_ev     = bus.btn_inc & ~prev_inc;
        in_set     = (state != RUN);
        rep_ev     = in_set & bus.tick & bus.btn_inc & (hold_cnt >= REPEAT_W);
        // The tick that brings idle_cnt up to the limit ends the set session,
        // unless this same cycle has activity that resets the idle count.
        timeout    = in_set & bus.tick & ~mode_ev & ~inc_ev & ~rep_ev & (idle_cnt >= IDLE_M1);
        // A mode press wins over a simultaneous increment (edge or repeat).
        inc_fire   = in_set & ~mode_ev & (inc_ev | rep_ev);
        clr_pulse  = (state == SET_MIN) & mode_ev;
        next_state = state;

        case (state)
            RUN: begin
                if (mode_ev) begin
                    next_state = SET_HOUR;
                end else begin
                    next_state = RUN;
                end
            end
            SET_HOUR: begin
                if (mode_ev) begin
                    next_state = SET_MIN;
                end else if (timeout) begin
                    next_state = RUN;
                end else begin
                    next_state = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (mode_ev || timeout) begin
                    next_state = RUN;
                end else begin
                    next_state = SET_MIN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase

        state_chg = (next_state != state);

        if (state_chg) begin
            next_blink = 1'b0;
        end else if (in_set && bus.tick) begin
            next_blink = ~blink_phase;
        end else begin
            next_blink = blink_phase;
        end

        if (state_chg || !bus.btn_inc) begin
            next_hold = 8'd0;
        end else if (in_set && bus.tick && (hold_cnt != 8'hFF)) begin
            next_hold = hold_cnt + 8'd1;
        end else begin
            next_hold = hold_cnt;
        end

        if (state_chg || mode_ev || inc_ev || rep_ev) begin
            next_idle = 8'd0;
        end else if (in_set && bus.tick && (idle_cnt != 8'hFF)) begin
            next_idle = idle_cnt + 8'd1;
        end else begin
            next_idle = idle_cnt;
        end
    end

    // State, history, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RUN;
            prev_mode      <= 1'b1;
            prev_inc       <= 1'b1;
            blink_phase    <= 1'b0;
            hold_cnt       <= 8'd0;
            idle_cnt       <= 8'd0;
            bus.sec_cin    <= 1'b0;
            bus.min_force  <= 1'b0;
            bus.hour_force <= 1'b0;
            bus.sec_clr_n  <= 1'b1;
            bus.mode       <= 2'd0;
            bus.blank_hour <= 1'b0;
            bus.blank_min  <= 1'b0;
        end else begin
            state          <= next_state;
            prev_mode      <= bus.btn_mode;
            prev_inc       <= bus.btn_inc;
            blink_phase    <= next_blink;
            hold_cnt       <= next_hold;
            idle_cnt       <= next_idle;
            bus.sec_cin    <= (state == RUN) & bus.tick;
            bus.min_force  <= inc_fire & (state == SET_MIN);
            bus.hour_force <= inc_fire & (state == SET_HOUR);
            bus.sec_clr_n  <= ~clr_pulse;
            bus.mode       <= next_state;
            bus.blank_hour <= (next_state == SET_HOUR) & next_blink;
            bus.blank_min  <= (next_state == SET_MIN) & next_blink;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl. Stimulus pushes each hand-computed output
// event (pulse or level change, with the cycle it must appear in) into a
// scoreboard. A monitor on the falling edge pops and compares every event
// the DUT actually shows.
module tb_clock_set_ctrl;

    localparam int K_SEC  = 0;
    localparam int K_MIN  = 1;
    localparam int K_HOUR = 2;
    localparam int K_CLR  = 3;
    localparam int K_MODE = 4;
    localparam int K_BH   = 5;
    localparam int K_BM   = 6;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic [1:0] last_mode = 2'd0;
    logic last_bh = 1'b0;
    logic last_bm = 1'b0;
    ev_t  evq[$];

    clock_set_if bus ();

    clock_set_ctrl #(.IDLE_TIMEOUT(10), .REPEAT_DLY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_SEC:   return "sec_cin";
            K_MIN:   return "min_force";
            K_HOUR:  return "hour_force";
            K_CLR:   return "sec_clr_n";
            K_MODE:  return "mode";
            K_BH:    return "blank_hour";
            K_BM:    return "blank_min";
            default: return "unknown";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int v, input int c);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.cyc  = c;
        evq.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        int idx = -1;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].kind == k) begin
                idx = i;
                break;
            end
        end
        n_vec++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s: got value %0d at cycle %0d, required no event", kname(k), v, cyc);
        end else begin
            if (evq[idx].cyc != cyc || evq[idx].val != v) begin
                n_fail++;
                $display("FAIL %s: got value %0d at cycle %0d, required %0d at cycle %0d",
                         kname(k), v, cyc, evq[idx].val, evq[idx].cyc);
            end
            evq.delete(idx);
        end
    endtask

    task automatic dcheck(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        dcheck({tag, " sec_cin"},    int'(bus.sec_cin),    0);
        dcheck({tag, " min_force"},  int'(bus.min_force),  0);
        dcheck({tag, " hour_force"}, int'(bus.hour_force), 0);
        dcheck({tag, " sec_clr_n"},  int'(bus.sec_clr_n),  1);
        dcheck({tag, " mode"},       int'(bus.mode),       0);
        dcheck({tag, " blank_hour"}, int'(bus.blank_hour), 0);
        dcheck({tag, " blank_min"},  int'(bus.blank_min),  0);
    endtask

    // Apply one clock's worth of inputs; they are sampled at edge cyc+1.
    task automatic step(input logic r, input logic t, input logic m, input logic i);
        @(negedge clk);
        rst          = r;
        bus.tick     = t;
        bus.btn_mode = m;
        bus.btn_inc  = i;
    endtask

    // Monitor: every visible output event is popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.sec_cin === 1'b1)    observe(K_SEC, 1);
            if (bus.min_force === 1'b1)  observe(K_MIN, 1);
            if (bus.hour_force === 1'b1) observe(K_HOUR, 1);
            if (bus.sec_clr_n !== 1'b1)  observe(K_CLR, int'(bus.sec_clr_n));
            if (bus.mode !== last_mode) begin
                observe(K_MODE, int'(bus.mode));
                last_mode <= bus.mode;
            end
            if (bus.blank_hour !== last_bh) begin
                observe(K_BH, int'(bus.blank_hour));
                last_bh <= bus.blank_hour;
            end
            if (bus.blank_min !== last_bm) begin
                observe(K_BM, int'(bus.blank_min));
                last_bm <= bus.blank_min;
            end
        end
    end

    initial begin
        bus.tick     = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_values("reset");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 1: five ticks in RUN are forwarded one clk later
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            expect_ev(K_SEC, 1, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // 2: enter SET_HOUR, three presses, four frozen ticks with blink
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 1, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            expect_ev(K_HOUR, 1, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            expect_ev(K_BH, (k % 2 == 0) ? 1 : 0, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // 3: SET_MIN, two presses, back to RUN with one seconds clear
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 2, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            expect_ev(K_MIN, 1, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_CLR, 0, cyc + 1);
        expect_ev(K_MODE, 0, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect_ev(K_SEC, 1, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 4: SET_MIN with btn_inc held over six ticks -> edge + repeats on ticks 3..6
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 1, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 2, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        expect_ev(K_MIN, 1, cyc + 1);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (k >= 3) expect_ev(K_MIN, 1, cyc + 1);
            expect_ev(K_BM, (k % 2 == 1) ? 1 : 0, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_CLR, 0, cyc + 1);
        expect_ev(K_MODE, 0, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 5: SET_HOUR idle for ten ticks -> RUN on the tenth, no clear
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 1, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            expect_ev(K_BH, (k % 2 == 1 && k != 10) ? 1 : 0, cyc + 1);
            if (k == 10) expect_ev(K_MODE, 0, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // 6a: simultaneous mode and inc in SET_HOUR -> SET_MIN, no force
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_ev(K_MODE, 1, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        expect_ev(K_MODE, 2, cyc + 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // 6b: reset mid-SET_MIN with btn_inc held, then release while still held
        step(1'b1, 1'b0, 1'b0, 1'b1);
        expect_ev(K_MIN, 1, cyc + 1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        expect_ev(K_BM, 1, cyc + 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_ev(K_MODE, 0, cyc + 1);
        expect_ev(K_BM, 0, cyc + 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_reset_values("mid reset");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            expect_ev(K_SEC, 1, cyc + 1);
            step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Every expected event must have been seen
        while (evq.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got no event, required %0d at cycle %0d",
                     kname(evq[0].kind), evq[0].val, evq[0].cyc);
            evq.delete(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode and time-setting controller for the digital clock counter chain (seconds mod-60, minutes mod-60, hours mod-24). It gates the 1 Hz tick into the seconds stage during normal running. In set modes it freezes time, injects manual increments into the hour or minute stage, and drives the display blink enables. It sits between the button front end (synchronised, debounced levels) and the cascaded counters; the top level ORs its force pulses with each stage's incoming carry.

Parameters:
IDLE_TIMEOUT, 10, ticks with no button activity in a set state before returning to RUN (legal 1..255)
REPEAT_DLY, 2, ticks btn_inc must be held before auto-repeat starts (legal 1..255)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
tick  input  1  one-cycle pulse, 1 Hz, from prescaler
btn_mode  input  1  mode button level, debounced, active-high
btn_inc  input  1  increment button level, debounced, active-high
sec_cin  output  1  carry-in to seconds counter
min_force  output  1  one-cycle forced increment to minutes stage
hour_force  output  1  one-cycle forced increment to hours stage
sec_clr_n  output  1  one-cycle active-low clear to seconds counter
mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN
blank_hour  output  1  1 = hour digits blanked (blink phase)
blank_min  output  1  1 = minute digits blanked (blink phase)

Behaviour:
- All outputs registered; one clk of latency from the causing input.
- Reset, sampled at posedge clk while rst=0: state RUN; sec_cin, min_force, hour_force, blank_hour, blank_min = 0; sec_clr_n = 1; mode = 0; timeout and hold counters = 0.
- Reset: button-history registers load 1, so a button held through reset release produces no edge.
- Edges: mode_ev = btn_mode & ~prev_mode; inc_ev = btn_inc & ~prev_inc.
- FSM transitions:
  - RUN -mode_ev-> SET_HOUR.
  - SET_HOUR -mode_ev-> SET_MIN.
  - SET_MIN -mode_ev-> RUN, with sec_clr_n = 0 for exactly one cycle on entry to RUN.
  - SET_HOUR/SET_MIN -timeout-> RUN, with no seconds clear.
- RUN:
  - sec_cin = tick delayed one cycle.
  - force outputs 0; blank outputs 0.
  - inc_ev ignored.
  - A tick in the same cycle as mode_ev is still forwarded.
- SET_HOUR / SET_MIN:
  - sec_cin held 0; time is frozen.
  - inc_ev produces one hour_force (SET_HOUR) or min_force (SET_MIN) pulse next cycle.
  - Wrap-around is handled by the counter itself: 23->0 and 59->0 occur without a carry into the next stage, because forced pulses bypass the carry chain.
- Simultaneous mode_ev and inc_ev: mode wins; the increment is discarded.
- Blink:
  - blink_phase toggles on each tick in set states and clears to 0 on entering any state.
  - blank_hour = blink_phase in SET_HOUR; blank_min = blink_phase in SET_MIN.
- Auto-repeat:
  - hold_cnt increments (saturating at 255) on each tick while btn_inc=1 in a set state.
  - hold_cnt clears when btn_inc=0 or the state changes.
  - When hold_cnt >= REPEAT_DLY, each further tick with btn_inc=1 generates one force pulse for the current state.
- Timeout:
  - idle_cnt increments on each tick in set states.
  - idle_cnt clears on mode_ev, inc_ev, any auto-repeat pulse, or a state change.
  - When idle_cnt reaches IDLE_TIMEOUT, the FSM goes to RUN on the following clk.
- Reset mid-operation (any state): immediate return to the reset values above; no force or clear pulse is emitted.
- At most one force pulse per cycle; min_force and hour_force are never asserted together.

Test Plan:
1. Reset, then 5 ticks in RUN -> 5 sec_cin pulses, each 1 cycle after its tick; mode=0; no force pulses.
2. mode_ev, then 3 inc_ev (buttons released between presses) -> mode=1; 3 hour_force pulses; sec_cin stays 0 during subsequent ticks; blank_hour toggles each tick.
3. From SET_HOUR: mode_ev, 2 inc_ev, mode_ev -> mode 1->2->0; 2 min_force pulses; exactly one sec_clr_n low cycle on return to RUN.
4. SET_MIN, btn_inc held 6 ticks with REPEAT_DLY=2 -> 1 edge pulse plus 4 repeat pulses (ticks 3-6) = 5 min_force; no timeout.
5. SET_HOUR, no buttons for 10 ticks -> mode=0 one clk after the 10th tick; sec_clr_n stays 1; blank_hour=0.
6. mode_ev and inc_ev in the same cycle in SET_HOUR -> mode=2; no hour_force; separately, rst=0 mid-SET_MIN with btn_inc held -> all outputs at reset values; no min_force after release of rst.
